shared_reg_arbiter: RTL

// Round-robin arbiter and write controller for one shared WIDTH-bit register built from D flip-flops.
// Up to NUM_REQ requesters compete for write ownership using a req/grant handshake.
// The block grants one owner at a time, applies only that owner's writes and forces release after MAX_HOLD cycles.

---
 rtl/shared_reg_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write controller for one shared WIDTH-bit register.
// One requester owns the register at a time; only its writes are applied,
// and ownership is forcibly withdrawn after MAX_HOLD consecutive cycles.
module shared_reg_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         wr_en,
  input  logic [NUM_REQ*WIDTH-1:0]   wr_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [2:0]                 owner,
  output logic                       busy,
  output logic [WIDTH-1:0]           reg_q,
  output logic                       timeout
);

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [2:0]           owner_q, owner_d;
  logic [2:0]           start_q, start_d;
  logic [7:0]           hold_q, hold_d;
  logic [WIDTH-1:0]     shared_q, shared_d;
  logic                 timeout_q, timeout_d;

  logic [2*NUM_REQ-1:0] req_rot;
  logic                 pick_found;
  logic [2:0]           pick_idx;
  int                   scan_sum;
  int                   next_start;
  logic                 owner_req;
  logic                 owner_wr;
  logic [WIDTH-1:0]     owner_data;

  // Round-robin pick: first asserted request at or after the start pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_sum   = 0;
    req_rot    = {req, req} >> start_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_rot[k]) begin
        pick_found = 1'b1;
        scan_sum   = int'(start_q) + k;
        if (scan_sum >= NUM_REQ) scan_sum = scan_sum - NUM_REQ;
        pick_idx   = 3'(scan_sum);
      end
    end
    next_start = int'(pick_idx) + 1;
    if (next_start >= NUM_REQ) next_start = 0;
  end

  // Current owner's request, write strobe and data, selected by the one-hot grant.
  always_comb begin
    owner_req  = |(req & grant_q);
    owner_wr   = |(wr_en & grant_q);
    owner_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) owner_data = wr_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state logic for ownership, hold counter and the shared register.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    start_d   = start_q;
    hold_d    = hold_q;
    shared_d  = shared_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          state_d = GRANTED;
          grant_d = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          start_d = 3'(next_start);
          hold_d  = 8'd1;
        end
      end
      GRANTED: begin
        if (!owner_req) begin
          state_d = IDLE;
          grant_d = '0;
        end else begin
          if (owner_wr) shared_d = owner_data;
          if (hold_q == 8'(MAX_HOLD)) begin
            state_d   = IDLE;
            grant_d   = '0;
            timeout_d = 1'b1;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      start_q   <= '0;
      hold_q    <= '0;
      shared_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      start_q   <= start_d;
      hold_q    <= hold_d;
      shared_q  <= shared_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = (state_q == GRANTED);
  assign reg_q   = shared_q;
  assign timeout = timeout_q;

endmodule
